// File: rtl/l1_icache.sv
// l1_icache: 2-way set-associative read-only instruction cache with same-cycle hits
// and a single-line refill on a miss. Define ICACHE_PERF_CNT_EN to build hit/miss counters.
module l1_icache #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_read,
  input  logic [31:0]  icache_addr,
  output logic [31:0]  icache_rdata,
  output logic         icache_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
  localparam int S_SETS = 1 << S_INDEX;
  localparam int S_LINE = 8 << S_OFFSET;
  localparam int S_WSEL = S_OFFSET - 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]         state_q;
  logic [S_SETS-1:0]  valid_q [2];
  logic [S_TAG-1:0]   tag_q   [2][S_SETS];
  logic [S_LINE-1:0]  data_q  [2][S_SETS];
  logic [S_SETS-1:0]  lru_q;
  logic [S_TAG-1:0]   fill_tag_q;
  logic [S_INDEX-1:0] fill_idx_q;

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [S_WSEL-1:0]  req_word;
  logic               addr_unused;

  assign req_tag     = icache_addr[31 -: S_TAG];
  assign req_idx     = icache_addr[S_OFFSET +: S_INDEX];
  assign req_word    = icache_addr[2 +: S_WSEL];
  assign addr_unused = ^icache_addr[1:0];

  logic              way0_match;
  logic              way1_match;
  logic              hit_way;
  logic              idle_hit;
  logic              idle_miss;
  logic              victim;
  logic [S_LINE-1:0] hit_line;

  always_comb begin
    // NOTE: every output gets a default before any condition, so no path leaves one unassigned and no latch is inferred.
    icache_rdata = '0;
    way0_match   = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    way1_match   = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    hit_way      = ~way0_match;
    hit_line     = hit_way ? data_q[1][req_idx] : data_q[0][req_idx];
    idle_hit     = (state_q == IDLE) && icache_read && (way0_match || way1_match);
    idle_miss    = (state_q == IDLE) && icache_read && !(way0_match || way1_match);
    icache_resp  = idle_hit;
    if (idle_hit) begin
      icache_rdata = hit_line[{req_word, 5'b00000} +: 32];
    end
    // Prefer an empty way; only evict when the set is full.
    victim = lru_q[fill_idx_q];
    if (!valid_q[0][fill_idx_q]) begin
      victim = 1'b0;
    end else if (!valid_q[1][fill_idx_q]) begin
      victim = 1'b1;
    end
  end

  assign pmem_read    = (state_q == FILL);
  assign pmem_address = {fill_tag_q, fill_idx_q, {S_OFFSET{1'b0}}};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_hit) begin
            lru_q[req_idx] <= ~hit_way;
          end
          if (idle_miss) begin
            state_q    <= FILL;
            fill_tag_q <= req_tag;
            fill_idx_q <= req_idx;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid_q[victim][fill_idx_q] <= 1'b1;
            state_q                     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == FILL) && pmem_resp) begin
      tag_q[victim][fill_idx_q]  <= fill_tag_q;
      data_q[victim][fill_idx_q] <= pmem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (idle_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_icache.sv
// Scoreboarded bench for l1_icache: a set-level reference model predicts hit/miss, data
// and response cycle; a monitor pops expectations whenever the cache responds.
module tb_l1_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read;
  logic [31:0]  icache_addr;
  logic [31:0]  icache_rdata;
  logic         icache_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  l1_icache dut (
    .clk          (clk),
    .rst          (rst),
    .icache_read  (icache_read),
    .icache_addr  (icache_addr),
    .icache_rdata (icache_rdata),
    .icache_resp  (icache_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial forever #5 clk = ~clk;

  int unsigned checks    = 0;
  int unsigned failures  = 0;
  int unsigned cycle_cnt = 0;

  initial forever @(posedge clk) cycle_cnt++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cycle_cnt);
    end
  endtask

  // Backing memory contents: every line and every word within it is distinct.
  function automatic logic [255:0] line_of(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      l[32*w +: 32] = (la * 32'h9E3779B1) ^ (32'h01000193 * w) ^ 32'h5A5A0000;
    end
    if (la == 32'h00000060) l[63:32] = 32'h00A00093;
    return l;
  endfunction

  // Reference model: per set, two ways with a valid flag, a tag and the time of the
  // last hit; the least recently hit way (way 0 on a tie) is the eviction candidate.
  bit          m_valid [2][8];
  logic [23:0] m_tag   [2][8];
  int unsigned m_used  [2][8];
  int unsigned m_time;
  int unsigned m_hits;
  int unsigned m_misses;

  function automatic void m_reset();
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 8; s++) begin
        m_valid[w][s] = 1'b0;
        m_tag[w][s]   = '0;
        m_used[w][s]  = 0;
      end
    end
    m_time   = 0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic int m_lookup(input logic [31:0] a);
    int idx = int'(a[7:5]);
    for (int w = 0; w < 2; w++) begin
      if (m_valid[w][idx] && m_tag[w][idx] == a[31:8]) return w;
    end
    return -1;
  endfunction

  function automatic int m_fill(input logic [31:0] a);
    int idx = int'(a[7:5]);
    int w;
    if (!m_valid[0][idx])      w = 0;
    else if (!m_valid[1][idx]) w = 1;
    else                       w = (m_used[1][idx] < m_used[0][idx]) ? 1 : 0;
    m_valid[w][idx] = 1'b1;
    m_tag[w][idx]   = a[31:8];
    m_misses++;
    return w;
  endfunction

  function automatic void m_access(input logic [31:0] a, output bit hit, output logic [31:0] data);
    logic [255:0] line;
    int w;
    w   = m_lookup(a);
    hit = (w >= 0);
    if (!hit) w = m_fill(a);
    m_time++;
    m_used[w][int'(a[7:5])] = m_time;
    m_hits++;
    line = line_of({a[31:5], 5'b00000});
    data = line[int'(a[4:2])*32 +: 32];
  endfunction

  typedef struct {
    logic [31:0] data;
    bit          fill;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned fill_delay;
  logic [31:0] exp_fill_addr;
  bit          resp_auto;
  int unsigned stray_req;
  int unsigned stray_done;

  // Memory-side responder: answers fills after fill_delay cycles, or fires a stray pulse.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    stray_done = 0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_done) begin
        @(posedge clk); #1;
        pmem_rdata = {8{32'hDEADBEEF}};
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        stray_done++;
      end else if (pmem_read && resp_auto && !rst) begin
        check("pmem_address", pmem_address, exp_fill_addr);
        repeat (fill_delay) @(posedge clk);
        #1;
        pmem_rdata = line_of(exp_fill_addr);
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
      end
    end
  end

  // Monitor: pops one expectation per response and checks data, hit/miss and timing.
  initial begin : monitor
    bit   fill_seen;
    exp_t e;
    fill_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fill_seen = 1'b0;
      end else begin
        if (!icache_read) fill_seen = 1'b0;
        if (pmem_read) fill_seen = 1'b1;
        if (icache_resp) begin
          check("resp_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rdata", icache_rdata, e.data);
            check("went_to_memory", 32'(fill_seen), 32'(e.fill));
            check("resp_cycle", cycle_cnt, e.due);
          end
          fill_seen = 1'b0;
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input int unsigned d);
    bit          hit;
    logic [31:0] data;
    exp_t        e;
    bit          done;
    m_access(a, hit, data);
    fill_delay    = d;
    exp_fill_addr = {a[31:5], 5'b00000};
    @(posedge clk); #1;
    e.data = data;
    e.fill = !hit;
    e.due  = cycle_cnt + (hit ? 0 : d + 2);
    sb_q.push_back(e);
    icache_read = 1'b1;
    icache_addr = a;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (icache_resp) done = 1'b1;
    end
    if (!done) begin
      check("resp_timeout", 32'(done), 32'd1);
      sb_q.delete();
    end
    @(posedge clk); #1;
    icache_read = 1'b0;
  endtask

  // Miss, then withdraw the request once the fill has started; the line must still land.
  task automatic drop_fill(input logic [31:0] a, input int unsigned d);
    int  w;
    bit  done;
    w = m_fill(a);
    fill_delay    = d;
    exp_fill_addr = {a[31:5], 5'b00000};
    @(posedge clk); #1;
    icache_read = 1'b1;
    icache_addr = a;
    @(posedge clk); #1;
    icache_read = 1'b0;
    icache_addr = 32'hFFFFFFFC;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!pmem_read) done = 1'b1;
    end
    check("drop_fill_done", 32'(done), 32'd1);
  endtask

  task automatic stray_pulse();
    stray_req++;
    for (int i = 0; i < 8 && stray_done != stray_req; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_CNT_EN
    check({tag, "_hit_count"}, hit_count, m_hits);
    check({tag, "_miss_count"}, miss_count, m_misses);
`else
    check({tag, "_hit_count"}, hit_count, 32'd0);
    check({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst         = 1'b1;
    icache_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    bool_loop: begin end
    rst           = 1'b1;
    icache_read   = 1'b0;
    icache_addr   = '0;
    resp_auto     = 1'b1;
    stray_req     = 0;
    fill_delay    = 1;
    exp_fill_addr = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_resp", 32'(icache_resp), 32'd0);
    check("reset_rdata", icache_rdata, 32'd0);
    check("reset_pmem_read", 32'(pmem_read), 32'd0);
    check_counters("reset");

    // Cold miss, then a same-line hit.
    do_read(32'h00000064, 3);
    do_read(32'h00000068, 1);

    // Second way fill, LRU refresh of way 0, then eviction of way 1.
    do_read(32'h00000160, 2);
    do_read(32'h00000060, 1);
    do_read(32'h00000260, 1);
    do_read(32'h00000060, 1);
    do_read(32'h00000160, 2);
    check_counters("directed");

    // Request withdrawn mid-fill; the installed line then hits immediately.
    drop_fill(32'h00000400, 3);
    do_read(32'h00000404, 1);

    // Randomized traffic over five tags per set so that sets overflow.
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) stray_pulse();
      if ($urandom_range(0, 14) == 0 && m_lookup(a) < 0) drop_fill(a, $urandom_range(2, 4));
      else do_read(a, $urandom_range(1, 4));
    end
    check_counters("random");

    // Reset while a fill is outstanding; a later memory pulse must be ignored.
    resp_auto = 1'b0;
    @(posedge clk); #1;
    icache_read = 1'b1;
    icache_addr = 32'h000007E0;
    for (int i = 0; i < 4 && !pmem_read; i++) @(negedge clk);
    check("rst_fill_started", 32'(pmem_read), 32'd1);
    pulse_reset();
    stray_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_pmem_read", 32'(pmem_read), 32'd0);
      check("rst_no_resp", 32'(icache_resp), 32'd0);
    end
    for (int i = 0; i < 8 && stray_done != stray_req; i++) @(posedge clk);
    resp_auto = 1'b1;
    check_counters("after_reset");
    do_read(32'h000007E0, 2);

    // One cold miss followed by five hits from a clean reset.
    pulse_reset();
    do_read(32'h00000060, 2);
    for (int k = 1; k <= 5; k++) do_read(32'h00000060 + 32'(4 * k), 1);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_count", hit_count, 32'd6);
    check("perf_miss_count", miss_count, 32'd1);
`else
    check("perf_hit_count", hit_count, 32'd0);
    check("perf_miss_count", miss_count, 32'd0);
`endif
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_icache.md
Name: l1_icache

Overview:
- 2-way set-associative, read-only instruction cache.
- Sits directly downstream of the pipeline fetch port (icache_read/icache_addr/icache_rdata/icache_resp) and upstream of the shared physical-memory arbiter.
- Hits return in the same cycle, so fetch does not stall. A miss fills one 256-bit line, then the access is serviced.

Parameters:
S_OFFSET, 5, byte-offset bits per line (32-byte line, 8 words); fixed for a 256-bit line
S_INDEX, 3, set-index bits (8 sets); tag width = 32 - S_OFFSET - S_INDEX

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
icache_read  input  1  fetch request
icache_addr  input  32  fetch byte address; bits [1:0] ignored
icache_rdata  output  32  instruction word
icache_resp  output  1  rdata valid this cycle
pmem_read  output  1  line-fill request to arbiter
pmem_address  output  32  line address {tag,index,5'b0}
pmem_rdata  input  256  fill line; word w at bits [32w+31:32w]
pmem_resp  input  1  fill data valid, one-cycle pulse
hit_count  output  32  hit counter (optional feature)
miss_count  output  32  miss counter (optional feature)

Behaviour:
- Storage: per way, a valid bit array, tag array and data array (flop-based, combinational read). One LRU bit per set; LRU=0 means way 0 is least recent.
- Reset (rst high at a clock edge):
  - all valid bits, LRU bits and counters cleared; state <- IDLE.
  - pmem_read=0, icache_resp=0, icache_rdata=0 from the cycle after reset.
- FSM states: IDLE, FILL.
- IDLE:
  - Hit = icache_read && valid[way][index] && tag[way][index]==addr tag.
  - On hit: icache_resp=1 and icache_rdata = word addr[4:2] of the hit way, both combinational in the same cycle. At the edge, LRU[index] <- the other way.
  - On miss (read && !hit): resp=0; next state FILL.
  - Read low: resp=0, no state change.
- FILL:
  - pmem_read=1 and pmem_address={addr tag, index, 5'b0}, held every cycle until pmem_resp.
  - Victim way: the first invalid way (way 0 before way 1); if both ways are valid, the LRU way.
  - On pmem_resp: victim data <- pmem_rdata, tag written, valid <- 1; LRU is not updated by the fill. Next state IDLE; pmem_read drops the following cycle.
  - icache_resp=0 throughout FILL, even in the pmem_resp cycle.
- Miss latency: the fill is followed by a hit in IDLE, which updates LRU. resp arrives (cycles to pmem_resp) + 1 cycles after the miss is detected.
- Handshake: icache_addr must be stable while icache_read=1 and icache_resp=0. If icache_read drops during FILL, the fill still completes and installs the line.
- pmem_resp outside FILL is ignored.
- Both ways hitting the same set/tag must not occur; if it does, way 0 takes priority.
- Reset mid-FILL: the fill is abandoned, no line is installed, pmem_read=0 on the next cycle. A late pmem_resp is ignored.
- Tag compare uses the full tag width; index = addr[S_OFFSET+S_INDEX-1:S_OFFSET].

Optional Feature:
ICACHE_PERF_CNT_EN
- Defined:
  - hit_count increments at each edge where an IDLE hit is reported.
  - miss_count increments at each IDLE->FILL transition.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and clear on rst.
- Undefined: no counter flops are built; hit_count and miss_count are tied to 0.

Test Plan:
- Cold miss:
  - Stimulus: after reset, read addr 0x00000064; pmem_resp 3 cycles after pmem_read, line word1=0x00A00093.
  - Required: pmem_address=0x00000060, resp=0 for 4 cycles, then resp=1 with rdata=0x00A00093.
- Hit: read 0x00000068 after the above -> resp=1 in the same cycle with word2 of the line; pmem_read stays 0.
- Second-way fill and LRU eviction:
  - Stimulus: fill 0x00000060 (way0) and 0x00000160 (way1, same set 3), hit 0x00000060, then read 0x00000260.
  - Required: way1 is evicted, and a subsequent read of 0x00000060 hits while 0x00000160 misses.
- Reset mid-fill:
  - Stimulus: assert rst for 1 cycle while in FILL before pmem_resp, then pulse pmem_resp.
  - Required: pmem_read=0 after reset, the pulse is ignored, and a re-read of the same address misses again.
- Read deassert during fill: drop icache_read in FILL -> line still installed; the next read of that address hits in 1 cycle.
- Perf counters (macro defined):
  - Stimulus: 1 cold miss followed by 5 hits.
  - Required: miss_count=1, hit_count=6 (the post-fill hit counts); with the macro undefined, both read 0.
